// File: rtl/key_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_pkg : shared state encoding and constants for the key_repeat block.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package key_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] WAIT   = 2'b01;
  localparam logic [1:0] REPEAT = 2'b10;

  localparam int ACCEL_THRESHOLD = 8;
  localparam int RC_W            = 8;
  localparam logic [RC_W-1:0] RC_MAX = '1;

  // Accelerated repeat interval: half the normal period, never below 2 cycles.
  function automatic int accel_period(input int period);
    return ((period / 2) < 2) ? 2 : (period / 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_interval_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_interval_timer : clearable up-counter, done when cnt == term-1.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_interval_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  assign done = (r_cnt == (term - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_repeat : press/release/typematic-repeat pulse generator for one key.   |
// | Option KEY_REPEAT_ACCEL_EN halves the repeat period after 8 repeats.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_repeat
  import key_pkg::*;
#(
  parameter int HOLD_DELAY    = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_level,
  output logic            press_pulse,
  output logic            release_pulse,
  output logic            repeat_pulse,
  output logic            step_pulse,
  output logic            held,
  output logic [RC_W-1:0] repeat_count
);

  localparam logic [CNT_W-1:0] c_hold   = CNT_W'(HOLD_DELAY);
  localparam logic [CNT_W-1:0] c_period = CNT_W'(REPEAT_PERIOD);

  logic [1:0]       r_state, w_next_state;
  logic [CNT_W-1:0] w_term, w_period;
  logic             w_done, w_clr, w_en;
  logic             w_press, w_release, w_repeat;
  logic [RC_W-1:0]  w_rc;
  logic             r_press, r_release, r_repeat, r_step, r_held;
  logic [RC_W-1:0]  r_repeat_count;

`ifdef KEY_REPEAT_ACCEL_EN
  localparam logic [CNT_W-1:0] c_accel = CNT_W'(accel_period(REPEAT_PERIOD));
  // repeat_count reaches the threshold on the pulse that starts the first fast interval.
  assign w_period = (r_repeat_count >= RC_W'(ACCEL_THRESHOLD)) ? c_accel : c_period;
`else
  assign w_period = c_period;
`endif

  assign w_term = (r_state == WAIT) ? c_hold : w_period;
  assign w_en   = (r_state != IDLE);
  assign w_clr  = (r_state == IDLE) || !key_level || w_done;

  key_interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .en    (w_en),
    .term  (w_term),
    .done  (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (key_level) w_next_state = WAIT;
      WAIT:    if (!key_level) w_next_state = IDLE;
               else if (w_done) w_next_state = REPEAT;
      REPEAT:  if (!key_level) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Release is tested before terminal count so a same-edge release suppresses the repeat.
  always_comb begin
    w_press   = 1'b0;
    w_release = 1'b0;
    w_repeat  = 1'b0;
    w_rc      = r_repeat_count;
    case (r_state)
      IDLE: begin
        if (key_level) begin
          w_press = 1'b1;
          w_rc    = '0;
        end
      end
      WAIT, REPEAT: begin
        if (!key_level) begin
          w_release = 1'b1;
        end else if (w_done) begin
          w_repeat = 1'b1;
          if (r_state == WAIT) begin
            w_rc = RC_W'(1);
          end else if (r_repeat_count != RC_MAX) begin
            w_rc = r_repeat_count + RC_W'(1);
          end
        end
      end
      default: begin
        w_rc = r_repeat_count;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press        <= 1'b0;
      r_release      <= 1'b0;
      r_repeat       <= 1'b0;
      r_step         <= 1'b0;
      r_held         <= 1'b0;
      r_repeat_count <= '0;
    end else begin
      r_press        <= w_press;
      r_release      <= w_release;
      r_repeat       <= w_repeat;
      r_step         <= w_press | w_repeat;
      r_held         <= (w_next_state != IDLE);
      r_repeat_count <= w_rc;
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;
  assign step_pulse    = r_step;
  assign held          = r_held;
  assign repeat_count  = r_repeat_count;

endmodule
`default_nettype wire

// File: tb/tb_key_repeat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_repeat : self-checking bench for key_repeat (two parameter sets).   |
// | Follows KEY_REPEAT_ACCEL_EN when it is defined for the build.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_key_repeat;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_a, key_b;
  logic       a_press, a_rel, a_rep, a_step, a_held;
  logic [7:0] a_rc;
  logic       b_press, b_rel, b_rep, b_step, b_held;
  logic [7:0] b_rc;

  always #5 clk = ~clk;

  key_repeat #(.HOLD_DELAY(10), .REPEAT_PERIOD(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_level(key_a),
    .press_pulse(a_press), .release_pulse(a_rel), .repeat_pulse(a_rep),
    .step_pulse(a_step), .held(a_held), .repeat_count(a_rc)
  );

  key_repeat #(.HOLD_DELAY(2), .REPEAT_PERIOD(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_level(key_b),
    .press_pulse(b_press), .release_pulse(b_rel), .repeat_pulse(b_rep),
    .step_pulse(b_step), .held(b_held), .repeat_count(b_rc)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: schedule of repeat times measured in edges since the press.
  int m_hold[2] = '{10, 2};
  int m_per[2]  = '{4, 2};
  bit m_pressed[2], m_press[2], m_rel[2], m_rep[2];
  int m_k[2], m_next[2], m_rc[2];
  int n_press[2], n_rel[2], n_rep[2], n_step[2];

  typedef struct {
    bit key;
    bit press;
    bit rel;
    bit rep;
    bit hld;
    int rc;
  } vec_t;

  function automatic int period_now(input int id);
`ifdef KEY_REPEAT_ACCEL_EN
    if (m_rc[id] >= 8) return ((m_per[id] / 2) < 2) ? 2 : (m_per[id] / 2);
`endif
    return m_per[id];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pressed[i] = 0; m_press[i] = 0; m_rel[i] = 0; m_rep[i] = 0;
      m_k[i] = 0; m_next[i] = 0; m_rc[i] = 0;
    end
  endtask

  task automatic model_edge(input int id, input bit key);
    m_press[id] = 0; m_rel[id] = 0; m_rep[id] = 0;
    if (!m_pressed[id]) begin
      if (key) begin
        m_pressed[id] = 1; m_press[id] = 1; m_k[id] = 0;
        m_next[id] = m_hold[id]; m_rc[id] = 0;
      end
    end else if (!key) begin
      m_pressed[id] = 0; m_rel[id] = 1;
    end else begin
      m_k[id]++;
      if (m_k[id] == m_next[id]) begin
        m_rep[id] = 1;
        if (m_rc[id] < 255) m_rc[id]++;
        m_next[id] += period_now(id);
      end
    end
  endtask

  function automatic logic [12:0] model_vec(input int id);
    return {m_press[id], m_rel[id], m_rep[id], m_press[id] | m_rep[id], m_pressed[id], 8'(m_rc[id])};
  endfunction

  function automatic logic [12:0] actual(input int id);
    if (id == 0) return {a_press, a_rel, a_rep, a_step, a_held, a_rc};
    return {b_press, b_rel, b_rep, b_step, b_held, b_rc};
  endfunction

  task automatic check_vec(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (press,rel,rep,step,held,rc) at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0; n_step[i] = 0;
    end
  endtask

  task automatic cycle(input bit ka, input bit kb);
    key_a = ka;
    key_b = kb;
    @(posedge clk);
    #1;
    model_edge(0, ka);
    model_edge(1, kb);
    check_vec("model_a", actual(0), model_vec(0));
    check_vec("model_b", actual(1), model_vec(1));
    n_press[0] += int'(a_press); n_rel[0] += int'(a_rel); n_rep[0] += int'(a_rep); n_step[0] += int'(a_step);
    n_press[1] += int'(b_press); n_rel[1] += int'(b_rel); n_rep[1] += int'(b_rep); n_step[1] += int'(b_step);
  endtask

  // Called #1 after an edge; asserts reset with no clock edge, then releases it with the given keys.
  task automatic apply_reset(input bit ka, input bit kb);
    rst_n = 1'b0;
    #1;
    check_vec("async_reset_a", actual(0), 13'd0);
    check_vec("async_reset_b", actual(1), 13'd0);
    model_reset();
    @(posedge clk);
    #1;
    key_a = ka;
    key_b = kb;
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   first_rep;
    int   exp_accel;
    bit   rk_a, rk_b;
    int   len_a, len_b;

    tbl[0] = '{key: 0, press: 0, rel: 0, rep: 0, hld: 0, rc: 0};
    tbl[1] = '{key: 1, press: 1, rel: 0, rep: 0, hld: 1, rc: 0};
    tbl[2] = '{key: 1, press: 0, rel: 0, rep: 0, hld: 1, rc: 0};
    tbl[3] = '{key: 1, press: 0, rel: 0, rep: 0, hld: 1, rc: 0};
    tbl[4] = '{key: 0, press: 0, rel: 1, rep: 0, hld: 0, rc: 0};
    tbl[5] = '{key: 1, press: 1, rel: 0, rep: 0, hld: 1, rc: 0};
    tbl[6] = '{key: 0, press: 0, rel: 1, rep: 0, hld: 0, rc: 0};
    tbl[7] = '{key: 0, press: 0, rel: 0, rep: 0, hld: 0, rc: 0};

    rst_n = 1'b0;
    key_a = 1'b0;
    key_b = 1'b0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    apply_reset(0, 0);

    // Table vectors, including a one-cycle minimum press.
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].key, 1'b0);
      check_vec($sformatf("table_%0d", i), actual(0),
                {tbl[i].press, tbl[i].rel, tbl[i].rep, tbl[i].press | tbl[i].rep, tbl[i].hld, 8'(tbl[i].rc)});
    end

    // Short press of 5 cycles.
    clear_counts();
    repeat (5) cycle(1, 0);
    repeat (2) cycle(0, 0);
    check_int("short_press_cnt", n_press[0], 1);
    check_int("short_release_cnt", n_rel[0], 1);
    check_int("short_repeat_cnt", n_rep[0], 0);
    check_int("short_rc", int'(a_rc), 0);

    // Long hold of 30 cycles: repeats at 11, 15, 19, 23, 27.
    clear_counts();
    first_rep = -1;
    for (int t = 1; t <= 30; t++) begin
      cycle(1, 0);
      check_int("long_held", int'(a_held), 1);
      if (a_rep && first_rep < 0) first_rep = t;
    end
    check_int("long_first_repeat_t", first_rep, 11);
    check_int("long_repeat_cnt", n_rep[0], 5);
    check_int("long_step_cnt", n_step[0], 6);
    check_int("long_rc", int'(a_rc), 5);
    repeat (2) cycle(0, 0);
    check_int("long_rc_kept", int'(a_rc), 5);

    // Release on the very edge the first repeat would fire.
    repeat (10) cycle(1, 0);
    cycle(0, 0);
    check_vec("release_on_terminal", actual(0), {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    cycle(0, 0);

    // 60-cycle hold exercising the accelerated period when enabled.
    clear_counts();
`ifdef KEY_REPEAT_ACCEL_EN
    exp_accel = 18;
`else
    exp_accel = 13;
`endif
    repeat (60) cycle(1, 0);
    check_int("hold60_repeat_cnt", n_rep[0], exp_accel);

    // Asynchronous reset mid-REPEAT, released with the key still held.
    apply_reset(1, 0);
    cycle(1, 0);
    check_int("press_after_reset", int'(a_press), 1);
    repeat (3) cycle(0, 0);

    // Saturation on the fast instance.
    clear_counts();
    repeat (600) cycle(0, 1);
    check_int("sat_rc", int'(b_rc), 255);
    check_int("sat_repeat_cnt", n_rep[1], 299);
    cycle(0, 1);
    check_int("sat_still_repeating", int'(b_rep), 1);
    repeat (2) cycle(0, 0);

    // Random key activity with run lengths long enough to reach repeat and accel.
    rk_a = 0; rk_b = 0; len_a = 0; len_b = 0;
    for (int c = 0; c < 3000; c++) begin
      if (len_a == 0) begin rk_a = ~rk_a; len_a = int'($urandom_range(1, 80)); end
      if (len_b == 0) begin rk_b = ~rk_b; len_b = int'($urandom_range(1, 40)); end
      cycle(rk_a, rk_b);
      len_a--;
      len_b--;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
